// File: rtl/riscv_pkg.sv
// Shared RV64I encoding definitions: instruction format codes, opcodes and
// a helper for immediate range checks.
package riscv_pkg;

    typedef enum logic [2:0] {
        TIPO_I  = 3'd0,
        TIPO_S  = 3'd1,
        TIPO_SB = 3'd2,
        TIPO_U  = 3'd3,
        TIPO_UJ = 3'd4,
        TIPO_LI = 3'd5
    } tipo_t;

    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [31:0] NOP    = 32'h00000013;

    // True when imm[63:lsb] are all equal, i.e. the value sign-extends from bit lsb.
    function automatic logic top_equal(input logic [63:0] v, input int lsb);
        logic signed [63:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational range/alignment check of a 64-bit immediate against the
// selected instruction format, plus the LI expansion class.
module imm_fit_check
    import riscv_pkg::*;
(
    input  logic [2:0]  tipo,
    input  logic [63:0] imm,
    output logic        ok,
    output logic        li_short,
    output logic        li_two_words
);

    logic eq11, eq12, eq20, eq31;
    logic li_window;
    logic lo_zero;

    assign eq11    = top_equal(imm, 11);
    assign eq12    = top_equal(imm, 12);
    assign eq20    = top_equal(imm, 20);
    assign eq31    = top_equal(imm, 31);
    assign lo_zero = (imm[11:0] == 12'h000);

    // LUI sign-extends bit 31, so this top window cannot be built with LUI+ADDI.
    assign li_window = (imm >= 64'h0000_0000_7FFF_F800) && (imm <= 64'h0000_0000_7FFF_FFFF);

    always_comb begin
        ok = 1'b0;
        case (tipo)
            TIPO_I, TIPO_S: ok = eq11;
            TIPO_SB:        ok = eq12 && !imm[0];
            TIPO_UJ:        ok = eq20 && !imm[0];
            TIPO_U:         ok = eq31 && lo_zero;
            TIPO_LI:        ok = eq31 && !li_window;
            default:        ok = 1'b0;
        endcase
    end

    assign li_short     = (tipo == TIPO_LI) && eq11;
    assign li_two_words = (tipo == TIPO_LI) && ok && !eq11 && !lo_zero;

endmodule

// File: rtl/imm_encoder.sv
// RV64I immediate encoder: packs format fields and immediate into a 32-bit
// instruction word over a valid/ready stream; LI expands to one or two words.
module imm_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  tipo,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        erro,
    output logic        last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  rd_q;
    logic [11:0] imm_lo_q;

    logic        ok, li_short, li_two_words;
    logic [19:0] hi;
    logic [31:0] word1, word2;
    logic        erro1, last1;

    imm_fit_check u_fit (
        .tipo         (tipo),
        .imm          (imm),
        .ok           (ok),
        .li_short     (li_short),
        .li_two_words (li_two_words)
    );

    // The ADDI low part is sign-extended, so round the upper part up when imm[11] is set.
    assign hi = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        word1 = NOP;
        erro1 = 1'b1;
        last1 = 1'b1;
        if (ok) begin
            erro1 = 1'b0;
            case (tipo)
                TIPO_I:  word1 = {imm[11:0], rs1, funct3, rd, opcode};
                TIPO_S:  word1 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                TIPO_SB: word1 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                TIPO_U:  word1 = {imm[31:12], rd, opcode};
                TIPO_UJ: word1 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                TIPO_LI: begin
                    if (li_short) begin
                        word1 = {imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
                    end else begin
                        word1 = {hi, rd, OP_LUI};
                        last1 = !li_two_words;
                    end
                end
                default: word1 = NOP;
            endcase
        end
    end

    assign word2    = {imm_lo_q, rd_q, 3'b000, rd_q, OP_IMM};
    assign in_ready = (state == IDLE);

    // Word 1 is packed from the live request at acceptance; word 2 only needs rd and imm[11:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            instr     <= '0;
            erro      <= 1'b0;
            last      <= 1'b0;
            rd_q      <= '0;
            imm_lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= EMIT1;
                        out_valid <= 1'b1;
                        instr     <= word1;
                        erro      <= erro1;
                        last      <= last1;
                        rd_q      <= rd;
                        imm_lo_q  <= imm[11:0];
                    end
                end
                EMIT1: begin
                    if (out_ready) begin
                        if (last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end else begin
                            state <= EMIT2;
                            instr <= word2;
                            erro  <= 1'b0;
                            last  <= 1'b1;
                        end
                    end
                end
                EMIT2: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Encodes immediate instruction fields for RV64I: it is the inverse of the sign-extension/immediate-extraction unit in the decode stage. It takes an instruction format, the register/opcode fields and a 64-bit immediate, range-checks the immediate, and emits the packed 32-bit instruction word over a valid/ready stream. A pseudo-format `LI` expands a 32-bit signed constant load into one or two words (`ADDI`, or `LUI` + `ADDI`). It feeds the instruction-memory loader and self-test program generator.

## Interface
- No parameters. XLEN fixed at 64, ILEN fixed at 32.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted on the edge where `in_valid && in_ready`.
- `tipo` in 3: format. 0=I, 1=S, 2=SB, 3=U, 4=UJ, 5=LI. Codes 6–7 are illegal.
- `opcode` in 7: passed into bits [6:0]. Ignored for LI.
- `funct3` in 3: passed into bits [14:12] for I/S/SB. Ignored for U/UJ/LI.
- `rd`, `rs1`, `rs2` in 5 each: register fields, used as each format requires.
- `imm` in 64: full-width signed immediate.
- `out_valid` out 1: output word present.
- `out_ready` in 1: consumer accepts the word on the edge where `out_valid && out_ready`.
- `instr` out 32: packed instruction word.
- `erro` out 1: immediate out of range, misaligned, or illegal `tipo`. Qualified by `out_valid`.
- `last` out 1: final word of the current request. Qualified by `out_valid`.

## Operation
- **Input capture:** the request is registered on acceptance, so the inputs need not be held afterwards.
- **Word packing** (`{}` is MSB first):
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`
  - SB: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`
  - U: `{imm[31:12], rd, opcode}`
  - UJ: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`
- **Range rules** ("equal" means all bits in the range are equal):
  - I/S: `imm[63:11]` equal.
  - SB: `imm[63:12]` equal and `imm[0]=0`.
  - UJ: `imm[63:20]` equal and `imm[0]=0`.
  - U: `imm[63:31]` equal and `imm[11:0]=0`.
  - LI: `imm[63:31]` equal, and `imm` is not in `0x7FFFF800..0x7FFFFFFF`. That window is not reachable with RV64 `LUI` sign extension.
- **On any violation:** emit one word `instr=32'h00000013` (NOP) with `erro=1` and `last=1`.
- **LI, small constant:** if `imm[63:11]` is equal, emit one word `ADDI rd, x0, imm[11:0]` with `last=1`.
- **LI, general case:** `hi = imm[31:12] + imm[11]`, taken modulo 2^20.
  - Word 1 is `LUI rd, hi` (opcode `0110111`).
  - If `imm[11:0]=0`, word 1 is the only word and has `last=1`.
  - Otherwise word 2 is `ADDI rd, rd, imm[11:0]` (opcode `0010011`, funct3 `000`) with `last=1`.
- **State machine:**
  - IDLE → EMIT1 on accept.
  - EMIT1 → IDLE on output handshake when `last`.
  - EMIT1 → EMIT2 on output handshake when not `last`.
  - EMIT2 → IDLE on output handshake.
- `in_ready = (state == IDLE)`.

## Timing
- **Reset values:** state=IDLE, `out_valid=0`, `instr=0`, `erro=0`, `last=0`. `in_ready=1` once reset is released.
- **Latency:** request accepted at edge N → `out_valid=1` with word 1 after edge N.
- **Second LI word:** presented after the edge that completes the word-1 handshake.
- **Stability:** `instr`, `erro` and `last` stay stable while `out_valid && !out_ready`.
- **No bypass:** a new request is accepted no earlier than the cycle after the final handshake, so peak throughput is one word per 2 cycles.
- **Reset mid-request:** asserting `rst_n` low at any time drops any pending word and returns all outputs to their reset values immediately. No partial LI sequence resumes.
- **`out_ready` while idle:** has no effect.

## Structure
- **Shared package `riscv_pkg`** holds:
  - the `tipo_t` enum (I, S, SB, U, UJ, LI);
  - opcode constants `OP_IMM`, `OP_LUI`;
  - the NOP constant `32'h00000013`.
- **Sub-module `imm_fit_check`:** combinational. Inputs are `tipo` and `imm`. Outputs are `ok`, `li_short` and `li_two_words`.
- **`imm_encoder`:** contains the FSM, input register, output register and packing mux.

## Test plan
- **I-format:** `tipo=I`, opcode `0010011`, funct3 0, rd 1, rs1 2, imm −1 → `instr=0xFFF10093`, `erro=0`, `last=1`, one cycle after accept.
- **SB-format:** `tipo=SB`, opcode `1100011`, funct3 0, rs1 1, rs2 2, imm 8 → `0x00208463`. Repeat with imm 3 → `0x00000013`, `erro=1`.
- **LI, two words:** rd 5, imm `0x12345FFF` → `0x123462B7` (`last=0`), then `0xFFF28293` (`last=1`). Also: imm 100 → single word `0x06400293`. Also: imm `0x7FFFFFFF` → `erro=1`.
- **Backpressure:** hold `out_ready=0` for 3 cycles during an LI → `instr` stable and `in_ready=0` throughout. Word order is preserved.
- **Reset mid-LI:** pulse `rst_n` low after the word-1 handshake → `out_valid=0`, `in_ready=1` immediately. The next request is encoded normally.
